// File: rtl/tx_symbols_pkg.sv
// ----------------------------------------------------------------------------
// tx_symbols_pkg
// Shared definitions for the physical-layer transmit framing path:
//   - 8-bit K-code constants driven towards the 8b/10b encoder
//   - framer FSM state encoding
//   - width of the ordered-set symbol counter
// ----------------------------------------------------------------------------
package tx_symbols_pkg;

  // Control (K) symbol codes
  localparam logic [7:0] COM = 8'hBC;  // ordered-set comma
  localparam logic [7:0] PAD = 8'hF7;  // lane padding, never produced here
  localparam logic [7:0] SKP = 8'h1C;  // clock-compensation skip
  localparam logic [7:0] STP = 8'hFB;  // start of TLP
  localparam logic [7:0] SDP = 8'h5C;  // start of DLLP
  localparam logic [7:0] END = 8'hFD;  // good end of packet
  localparam logic [7:0] EDB = 8'hFE;  // end of nullified packet
  localparam logic [7:0] FTS = 8'h3C;  // fast training, reserved for L0s
  localparam logic [7:0] IDL = 8'h7C;  // logical idle

  // Holds SKP_LEN (at most 5)
  localparam int SYM_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // idle / choose next ordered set or packet
    ST_DATA  = 2'd1,  // forwarding packet bytes, END slot included
    ST_DRAIN = 2'd2,  // packet nullified, discarding remaining bytes
    ST_SKP   = 2'd3   // emitting the SKP symbols after COM
  } tx_state_e;

endpackage

// File: rtl/skp_interval_timer.sv
// ----------------------------------------------------------------------------
// skp_interval_timer
// Saturating cycle counter that requests a SKP ordered set once
// SKP_INTERVAL cycles have elapsed since the last clear.
//
// Ports:
//   CLK    in   symbol clock, posedge
//   RESET  in   asynchronous, active-high reset
//   clear  in   restart the interval (asserted in the cycle COM is chosen)
//   due    out  interval expired; held until clear
// ----------------------------------------------------------------------------
module skp_interval_timer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  output logic due
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SKP_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clearing in the decision cycle gives exactly SKP_INTERVAL cycles
  // between successive COM symbols.
  always_comb begin
    // NOTE: combinational next-state gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturation doubles as the pending flag, so requests never accumulate.
  assign due = (cnt_q == CNT_SAT);

endmodule

// File: rtl/tx_ordered_set_framer.sv
// ----------------------------------------------------------------------------
// tx_ordered_set_framer
// Transmit framer: wraps Tx_Buffer packets in STP/SDP ... END, nullifies
// underrun packets with EDB, fills gaps with IDL and inserts a SKP ordered
// set (COM + SKP_LEN x SKP) between packets every SKP_INTERVAL cycles.
// One symbol per clock, registered, with a K flag for the encoder.
//
// Ports:
//   CLK        in   symbol clock, posedge
//   RESET      in   asynchronous, active-high reset
//   VALID      in   Tx_Buffer holds a byte
//   Tx_Buffer  in   packet byte
//   LAST       in   Tx_Buffer is the final byte of the packet
//   TYPE       in   0 = TLP (STP), 1 = DLLP (SDP); used at packet start
//   READY      out  byte consumed when VALID & READY (decoded from state)
//   OUT        out  registered symbol
//   OUT_K      out  registered K flag (1 = control symbol)
// ----------------------------------------------------------------------------
module tx_ordered_set_framer
  import tx_symbols_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int CNT_W        = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VALID,
  input  logic [7:0] Tx_Buffer,
  input  logic       LAST,
  input  logic       TYPE,
  output logic       READY,
  output logic [7:0] OUT,
  output logic       OUT_K
);

  tx_state_e              state_q,    state_d;
  logic [SYM_CNT_W-1:0]   sym_cnt_q,  sym_cnt_d;
  logic                   end_pend_q, end_pend_d;  // END slot of DATA
  logic [7:0]             out_q,      out_d;
  logic                   out_k_q,    out_k_d;
  logic                   ready;
  logic                   skp_clear;
  logic                   skp_due;

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .CNT_W        (CNT_W)
  ) u_skp_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .clear (skp_clear),
    .due   (skp_due)
  );

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    end_pend_d = end_pend_q;
    out_d      = IDL;
    out_k_d    = 1'b1;
    skp_clear  = 1'b0;
    ready      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A due ordered set wins over a waiting packet; the packet's
        // first byte is left untouched until DATA.
        if (skp_due) begin
          out_d     = COM;
          skp_clear = 1'b1;
          sym_cnt_d = SYM_CNT_W'(SKP_LEN);
          state_d   = ST_SKP;
        end else if (VALID) begin
          out_d   = TYPE ? SDP : STP;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (end_pend_q) begin
          // Closing slot after the LAST byte; nothing is consumed here.
          out_d      = END;
          end_pend_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          ready = 1'b1;
          if (VALID) begin
            out_d   = Tx_Buffer;
            out_k_d = 1'b0;
            if (LAST) begin
              end_pend_d = 1'b1;
            end
          end else begin
            out_d   = EDB;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Swallow the rest of the nullified packet while sending idle.
        ready = 1'b1;
        if (VALID && LAST) begin
          state_d = ST_IDLE;
        end
      end

      ST_SKP: begin
        out_d     = SKP;
        sym_cnt_d = sym_cnt_q - SYM_CNT_W'(1);
        if (sym_cnt_q == SYM_CNT_W'(1)) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      end_pend_q <= 1'b0;
      out_q      <= IDL;
      out_k_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      end_pend_q <= end_pend_d;
      out_q      <= out_d;
      out_k_q    <= out_k_d;
    end
  end

  assign READY = ready;
  assign OUT   = out_q;
  assign OUT_K = out_k_q;

endmodule

// File: doc/tx_ordered_set_framer.md
Name: tx_ordered_set_framer

Overview:
- Parametrised successor of the 10-way control-symbol mux in the PCIe-style physical-layer transmit path.
- Replaces the externally driven CONTROL select with an internal FSM. The FSM frames Tx_Buffer packets with STP/SDP...END, emits IDL when there is no traffic, and inserts periodic SKP ordered sets between packets.
- Handles transmit underrun by nullifying the packet with EDB.
- Drives one 8-bit symbol plus a K-flag per clock into the encoder.

Parameters:
- SKP_INTERVAL, 1180: cycles between SKP ordered-set requests; legal range 16..65535.
- SKP_LEN, 3: number of SKP symbols following COM in each ordered set; legal range 1..5.
- CNT_W, 16: width of the SKP interval counter; must satisfy 2**CNT_W > SKP_INTERVAL.

Ports:
- CLK  input  1  transmit symbol clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high reset.
- VALID  input  1  Tx_Buffer has a byte available.
- Tx_Buffer  input  8  packet data byte.
- LAST  input  1  qualifies Tx_Buffer as the final byte of the packet.
- TYPE  input  1  0 = TLP (framed with STP), 1 = DLLP (framed with SDP); sampled at packet start.
- READY  output  1  byte consumed this cycle when VALID & READY; combinational from state.
- OUT  output  8  registered symbol.
- OUT_K  output  1  registered; 1 = OUT is a control (K) symbol, 0 = data.

Behaviour:
- Reset (async, active-high): state IDLE, OUT=IDL (8'h7C), OUT_K=1, SKP counter=0, skp_due=0. READY=0 while RESET is high.
- Clocking: OUT/OUT_K are registered. The symbol for the decision made in cycle t appears at t+1, so latency from byte acceptance to OUT is exactly 1 cycle.
- States: IDLE, DATA, DRAIN, SKP.
- IDLE:
  - skp_due=1: emit COM (K), load sym_cnt=SKP_LEN, go to SKP. SKP has priority over a pending packet.
  - else VALID=1: emit STP if TYPE=0, SDP if TYPE=1 (K); go to DATA. The byte is not consumed.
  - else: emit IDL (K).
- DATA: READY=1.
  - VALID=1, LAST=0: emit Tx_Buffer (K=0); stay.
  - VALID=1, LAST=1: emit Tx_Buffer (K=0); next cycle emit END (K), then go to IDLE. The END slot is modelled as a one-cycle sub-step of DATA with READY=0.
  - VALID=0 (underrun): emit EDB (K); go to DRAIN.
- DRAIN: READY=1. Accepted bytes are discarded; OUT=IDL (K). Leave to IDLE on VALID & LAST. skp_due is honoured only after returning to IDLE.
- SKP: emit SKP (8'h1C, K) while sym_cnt>0, decrementing each cycle; on the last SKP go to IDLE. READY=0.
- Each ordered set is exactly 1 COM + SKP_LEN SKP symbols and is never interleaved with packet bytes.
- SKP counter:
  - Increments every cycle and saturates at SKP_INTERVAL-1, at which point skp_due=1.
  - Cleared to 0, and skp_due cleared, in the cycle COM is emitted.
  - A SKP request during a packet is deferred until after END/EDB/DRAIN completes. At most one ordered set is pending; requests do not accumulate.
- Simultaneous events:
  - skp_due and VALID in IDLE in the same cycle: ordered set first, then STP.
  - LAST on a one-byte packet is legal: sequence is STP, D0, END.
- Zero-length packets are impossible; a packet always has at least one byte.
- Reset mid-packet: output returns to IDL immediately (async). No END/EDB is emitted and the counter is cleared.
- Never-emitted codes: PAD, FTS and STP-in-data are never produced by this block. FTS is reserved for a future L0s mode.

Decomposition:
- Shared package tx_symbols_pkg holds:
  - K-code constants COM=8'hBC, PAD=8'hF7, SKP=8'h1C, STP=8'hFB, SDP=8'h5C, END=8'hFD, EDB=8'hFE, FTS=8'h3C, IDL=8'h7C.
  - The state enum typedef.
- One sub-module, skp_interval_timer (parameters SKP_INTERVAL, CNT_W; ports CLK, RESET, clear, due), contains the saturating counter.

Test Plan:
- Reset release, VALID=0 for 10 cycles -> OUT=8'h7C, OUT_K=1 every cycle; READY=0.
- TLP of bytes 8'h11,8'h22,8'h33 (LAST on 33), VALID held -> OUT sequence FB(K),11,22,33,FD(K),7C(K); READY high for exactly 3 cycles.
- DLLP with VALID dropped after byte 8'hA0, then bytes A1, A2(LAST) -> OUT sequence 5C(K),A0,FE(K),7C,7C,7C; A1/A2 consumed and discarded.
- SKP_INTERVAL=16, SKP_LEN=3, no traffic -> BC,1C,1C,1C (all K) every 16 cycles after reset, IDL otherwise.
- SKP_INTERVAL=16, 20-byte packet starting at cycle 10 -> no COM inside the packet; COM,1C×3 immediately after END; the next ordered set comes 16 cycles after that COM.
- RESET asserted during byte 2 of a packet -> OUT=7C/K=1 asynchronously, READY=0; the next packet starts cleanly with STP.
